// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU control path.
//   phase_t     - encoded sequencer state (IDLE plus the four instruction phases)
//   PHASE_COUNT - number of real instruction phases (one strobe per phase)
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4
  } phase_t;

  localparam int PHASE_COUNT = 4;

endpackage

// File: rtl/cpu_phase_sequencer_instr_counter.sv
// instr_counter: COUNT_W-bit wrapping counter with enable.
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, clears count
//   enable - count advances by one on each rising edge while high
//   count  - current count, wraps modulo 2^COUNT_W
module instr_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + COUNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: rotates fetch -> decode -> execute -> writeback forever,
// starting from IDLE after reset, and counts completed instructions.
//   clock       - rising-edge clock
//   reset       - asynchronous active-high reset, forces IDLE
//   fetch       - high during FETCH
//   decode      - high during DECODE
//   execute     - high during EXECUTE
//   writeback   - high during WRITEBACK
//   phase       - encoded state (IDLE=0 .. WRITEBACK=4)
//   instr_count - completed instruction cycles (WRITEBACK -> FETCH transitions)
module cpu_phase_sequencer
  import cpu_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic               fetch,
  output logic               decode,
  output logic               execute,
  output logic               writeback,
  output logic [2:0]         phase,
  output logic [COUNT_W-1:0] instr_count
);

  phase_t                 state_reg;
  phase_t                 state_next;
  logic [PHASE_COUNT-1:0] strobe;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: unconditional rotation; unused encodings fall back to IDLE
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:      state_next = FETCH;
      FETCH:     state_next = DECODE;
      DECODE:    state_next = EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = FETCH;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode: strobe[i] belongs to the phase encoded as i+1, so IDLE
  // and the unused encodings 5..7 leave every strobe low.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < PHASE_COUNT; i++) begin
      strobe[i] = (state_reg == phase_t'(3'(i + 1)));
    end
  end

  assign fetch     = strobe[0];
  assign decode    = strobe[1];
  assign execute   = strobe[2];
  assign writeback = strobe[3];
  assign phase     = state_reg;

  // Count advances on the edge that leaves WRITEBACK, i.e. when an
  // instruction completes; IDLE -> FETCH never counts.
  instr_counter #(
    .COUNT_W(COUNT_W)
  ) u_instr_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (state_reg == WRITEBACK),
    .count  (instr_count)
  );

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed testbench for cpu_phase_sequencer. A default-width instance and a
// COUNT_W=2 instance share clock and reset.
module tb_cpu_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        fetch, decode, execute, writeback;
  logic [2:0]  phase;
  logic [15:0] instr_count;

  logic        fetch2, decode2, execute2, writeback2;
  logic [2:0]  phase2;
  logic [1:0]  instr_count2;

  int checks = 0;
  int errors = 0;

  cpu_phase_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .fetch       (fetch),
    .decode      (decode),
    .execute     (execute),
    .writeback   (writeback),
    .phase       (phase),
    .instr_count (instr_count)
  );

  cpu_phase_sequencer #(.COUNT_W(2)) dut_w2 (
    .clock       (clock),
    .reset       (reset),
    .fetch       (fetch2),
    .decode      (decode2),
    .execute     (execute2),
    .writeback   (writeback2),
    .phase       (phase2),
    .instr_count (instr_count2)
  );

  // One full clock period; returns just after the falling edge.
  task automatic tick();
    clock = 1'b1;
    #5;
    clock = 1'b0;
    #5;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #20;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #20;
    checks++;
    if ({fetch, decode, execute, writeback} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=0000", {fetch, decode, execute, writeback});
    end
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_phase got=%0d want=0", phase);
    end
    checks++;
    if (instr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d want=0", instr_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_phase got=%0d want=0", phase);
    end
    $display("test_reset: strobes=%b phase=%0d count=%0d",
             {fetch, decode, execute, writeback}, phase, instr_count);
  endtask

  task automatic test_sequence();
    logic [3:0]  exp_str [5];
    logic [2:0]  exp_ph  [5];
    logic [15:0] exp_cnt [5];
    exp_str = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    exp_ph  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    exp_cnt = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({fetch, decode, execute, writeback} !== exp_str[k]) begin
        errors++;
        $display("FAIL seq_strobes edge=%0d got=%b want=%b", k + 1,
                 {fetch, decode, execute, writeback}, exp_str[k]);
      end
      checks++;
      if (phase !== exp_ph[k]) begin
        errors++;
        $display("FAIL seq_phase edge=%0d got=%0d want=%0d", k + 1, phase, exp_ph[k]);
      end
      checks++;
      if (instr_count !== exp_cnt[k]) begin
        errors++;
        $display("FAIL seq_count edge=%0d got=%0d want=%0d", k + 1, instr_count, exp_cnt[k]);
      end
      $display("test_sequence: edge=%0d strobes=%b phase=%0d count=%0d", k + 1,
               {fetch, decode, execute, writeback}, phase, instr_count);
    end
  endtask

  task automatic test_reset_mid();
    // Abort in FETCH
    pulse_reset();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({fetch, decode, execute, writeback, phase} !== 7'd0) begin
      errors++;
      $display("FAIL mid_fetch_reset got strobes=%b phase=%0d want strobes=0000 phase=0",
               {fetch, decode, execute, writeback}, phase);
    end
    $display("test_reset_mid: abort in FETCH strobes=%b phase=%0d",
             {fetch, decode, execute, writeback}, phase);
    reset = 1'b0;
    #1;
    tick();
    checks++;
    if ({fetch, decode} !== 2'b10 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_fetch_restart got fetch=%b decode=%b count=%0d want fetch=1 decode=0 count=0",
               fetch, decode, instr_count);
    end
    // Run to EXECUTE of the second instruction (count = 1), then abort
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (execute !== 1'b1 || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_exec_setup got execute=%b count=%0d want execute=1 count=1",
               execute, instr_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({fetch, decode, execute, writeback, phase} !== 7'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_exec_reset got strobes=%b phase=%0d count=%0d want 0000/0/0",
               {fetch, decode, execute, writeback}, phase, instr_count);
    end
    reset = 1'b0;
    #1;
    tick();
    checks++;
    if ({fetch, decode, execute, writeback} !== 4'b1000 || phase !== 3'd1 ||
        instr_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_exec_restart got strobes=%b phase=%0d count=%0d want 1000/1/0",
               {fetch, decode, execute, writeback}, phase, instr_count);
    end
    $display("test_reset_mid: abort in EXECUTE then restart strobes=%b phase=%0d count=%0d",
             {fetch, decode, execute, writeback}, phase, instr_count);
  endtask

  task automatic test_reset_held();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({fetch, decode, execute, writeback} !== 4'b0000 || phase !== 3'd0) begin
        errors++;
        $display("FAIL held_reset edge=%0d got strobes=%b phase=%0d want 0000/0", k + 1,
                 {fetch, decode, execute, writeback}, phase);
      end
      $display("test_reset_held: edge=%0d strobes=%b phase=%0d", k + 1,
               {fetch, decode, execute, writeback}, phase);
    end
    reset = 1'b0;
    #1;
    tick();
    checks++;
    if (fetch !== 1'b1 || phase !== 3'd1) begin
      errors++;
      $display("FAIL held_release got fetch=%b phase=%0d want fetch=1 phase=1", fetch, phase);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_ph;
    logic [1:0] exp_cnt;
    pulse_reset();
    tick();  // now in FETCH, count 0
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_ph  = 3'((k % 4) + 1);
      exp_cnt = 2'((k / 4) % 4);
      checks++;
      if ($countones({fetch2, decode2, execute2, writeback2}) != 1) begin
        errors++;
        $display("FAIL wrap_onehot cycle=%0d got=%b want exactly one high", k,
                 {fetch2, decode2, execute2, writeback2});
      end
      checks++;
      if (phase2 !== exp_ph || instr_count2 !== exp_cnt) begin
        errors++;
        $display("FAIL wrap_state cycle=%0d got phase=%0d count=%0d want phase=%0d count=%0d",
                 k, phase2, instr_count2, exp_ph, exp_cnt);
      end
      $display("test_wrap: cycle=%0d strobes=%b phase=%0d count=%0d", k,
               {fetch2, decode2, execute2, writeback2}, phase2, instr_count2);
    end
    checks++;
    if (instr_count2 !== 2'd1) begin
      errors++;
      $display("FAIL wrap_final got=%0d want=1", instr_count2);
    end
    checks++;
    if (instr_count !== 16'd5) begin
      errors++;
      $display("FAIL wide_count got=%0d want=5", instr_count);
    end
  endtask

  task automatic test_illegal();
    pulse_reset();
    tick();
    tick();  // DECODE
    force dut.state_reg = cpu_pkg::phase_t'(3'd6);
    #1;
    release dut.state_reg;
    #1;
    checks++;
    if (phase !== 3'd6 || {fetch, decode, execute, writeback} !== 4'b0000) begin
      errors++;
      $display("FAIL illegal_forced got phase=%0d strobes=%b want phase=6 strobes=0000",
               phase, {fetch, decode, execute, writeback});
    end
    tick();
    checks++;
    if (phase !== 3'd0 || {fetch, decode, execute, writeback} !== 4'b0000) begin
      errors++;
      $display("FAIL illegal_recover got phase=%0d strobes=%b want phase=0 strobes=0000",
               phase, {fetch, decode, execute, writeback});
    end
    $display("test_illegal: after recovery edge phase=%0d strobes=%b",
             phase, {fetch, decode, execute, writeback});
    tick();
    checks++;
    if (fetch !== 1'b1 || phase !== 3'd1) begin
      errors++;
      $display("FAIL illegal_restart got fetch=%b phase=%0d want fetch=1 phase=1", fetch, phase);
    end
    $display("test_illegal: next edge phase=%0d fetch=%b", phase, fetch);
  endtask

  initial begin
    #5;
    test_reset();
    test_sequence();
    test_reset_mid();
    test_reset_held();
    test_wrap();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
